// File: rtl/barrido_display.sv
// Multiplexed 7-segment scanner: slot prescaler, digit selector,
// registered active-low outputs with a blanking guard at each slot start.
module barrido_display #(
  parameter int DIV = 100000,
  parameter int BLANK = 16,
  parameter int N_DIGITOS = 4,
  localparam int SELW = $clog2(N_DIGITOS)
) (
  input  logic                   reloj,
  input  logic                   reset,
  input  logic                   habilitar,
  input  logic [4*N_DIGITOS-1:0] digitos,
  input  logic [N_DIGITOS-1:0]   puntos,
  output logic                   tick_actualizacion,
  output logic [SELW-1:0]        digito_sel,
  output logic [N_DIGITOS-1:0]   anodos,
  output logic [6:0]             segmentos,
  output logic                   punto
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK);
  localparam logic [SELW-1:0] S_LAST = SELW'(N_DIGITOS - 1);

  logic [PW-1:0]        presc_q, presc_d;
  logic [SELW-1:0]      sel_q, sel_d;
  logic                 tick_q, tick_d;
  logic [N_DIGITOS-1:0] an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 pt_q, pt_d;

  logic                 activo;
  logic [3:0]           nib;
  logic                 dp;
  logic [N_DIGITOS-1:0] an_sel;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Digit mux by loop so non-power-of-2 counts never index past the bus
  always_comb begin
    nib = 4'h0;
    dp = 1'b0;
    an_sel = '1;
    for (int i = 0; i < N_DIGITOS; i++) begin
      if (sel_q == SELW'(i)) begin
        nib = digitos[4*i +: 4];
        dp = puntos[i];
        an_sel[i] = 1'b0;
      end
    end
  end

  assign activo = (presc_q >= P_BLANK);

  always_comb begin
    presc_d = presc_q;
    sel_d = sel_q;
    tick_d = 1'b0;
    an_d = '1;
    seg_d = 7'h7F;
    pt_d = 1'b1;
    if (habilitar) begin
      if (presc_q == P_LAST) begin
        presc_d = '0;
        tick_d = 1'b1;
        sel_d = (sel_q == S_LAST) ? '0 : sel_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
      if (activo) begin
        an_d = an_sel;
        seg_d = decode(nib);
        pt_d = ~dp;
      end
    end
  end

  always_ff @(posedge reloj) begin
    if (reset) begin
      presc_q <= '0;
      sel_q <= '0;
      tick_q <= 1'b0;
      an_q <= '1;
      seg_q <= 7'h7F;
      pt_q <= 1'b1;
    end else begin
      presc_q <= presc_d;
      sel_q <= sel_d;
      tick_q <= tick_d;
      an_q <= an_d;
      seg_q <= seg_d;
      pt_q <= pt_d;
    end
  end

  assign tick_actualizacion = tick_q;
  assign digito_sel = sel_q;
  assign anodos = an_q;
  assign segmentos = seg_q;
  assign punto = pt_q;

endmodule

// File: tb/tb_barrido_display.sv
// Bench for barrido_display: directed scenarios plus random stimulus,
// checked every cycle against a count-based display model.
module tb_barrido_display;

  localparam int DIV = 8;
  localparam int BLANK = 2;
  localparam int ND = 4;
  localparam int SELW = 2;

  logic            reloj = 1'b0;
  logic            reset;
  logic            habilitar;
  logic [15:0]     digitos;
  logic [3:0]      puntos;
  logic            tick_actualizacion;
  logic [SELW-1:0] digito_sel;
  logic [3:0]      anodos;
  logic [6:0]      segmentos;
  logic            punto;

  barrido_display #(
    .DIV(DIV),
    .BLANK(BLANK),
    .N_DIGITOS(ND)
  ) dut (
    .reloj(reloj),
    .reset(reset),
    .habilitar(habilitar),
    .digitos(digitos),
    .puntos(puntos),
    .tick_actualizacion(tick_actualizacion),
    .digito_sel(digito_sel),
    .anodos(anodos),
    .segmentos(segmentos),
    .punto(punto)
  );

  always #5 reloj = ~reloj;

  int checks = 0;
  int errors = 0;
  // enabled cycles since reset: slot position and digit follow from it
  int n = 0;

  logic [6:0] tbl [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic h,
                      input logic [15:0] d, input logic [3:0] pt);
    int p, s, nn;
    logic [3:0] ea;
    logic [6:0] es;
    logic ep, et;
    reset = r;
    habilitar = h;
    digitos = d;
    puntos = pt;
    ea = '1;
    es = 7'h7F;
    ep = 1'b1;
    et = 1'b0;
    nn = n;
    if (r) begin
      nn = 0;
    end else if (h) begin
      p = n % DIV;
      s = (n / DIV) % ND;
      if (p >= BLANK) begin
        ea[s] = 1'b0;
        es = tbl[d[4*s +: 4]];
        ep = ~pt[s];
      end
      et = (p == DIV - 1);
      nn = n + 1;
    end
    @(posedge reloj);
    #1;
    n = nn;
    chk("anodos", 32'(anodos), 32'(ea));
    chk("segmentos", 32'(segmentos), 32'(es));
    chk("punto", 32'(punto), 32'(ep));
    chk("tick", 32'(tick_actualizacion), 32'(et));
    chk("digito_sel", 32'(digito_sel), 32'((n / DIV) % ND));
    checks++;
    assert ($countones(~anodos) <= 1) else begin
      errors++;
      $error("FAIL onehot observed=%b expected=at_most_one_low", anodos);
    end
  endtask

  task automatic go_to(input int p, input int s,
                       input logic [15:0] d, input logic [3:0] pt);
    int k;
    k = 0;
    while (!((n % DIV) == p && ((n / DIV) % ND) == s) && k < 64) begin
      step(1'b0, 1'b1, d, pt);
      k++;
    end
    chk("go_to_bound", 32'(k < 64), 32'(1));
  endtask

  initial begin
    logic [15:0] d;
    logic [3:0] pt;
    reset = 1'b1;
    habilitar = 1'b0;
    digitos = 16'h0;
    puntos = 4'h0;

    step(1'b1, 1'b0, 16'h3A70, 4'h0);
    step(1'b1, 1'b1, 16'h3A70, 4'h0);
    chk("reset_seg", 32'(segmentos), 32'h7F);

    for (int i = 0; i < 5 * DIV; i++) step(1'b0, 1'b1, 16'h3A70, 4'h0);

    for (int i = 0; i < 100 * DIV; i++) begin
      d = 16'($urandom);
      pt = 4'($urandom);
      step(1'b0, 1'b1, d, pt);
    end

    go_to(5, 1, 16'h3A70, 4'h0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h3A70, 4'h0);
    chk("hold_sel", 32'(digito_sel), 32'(1));
    step(1'b0, 1'b1, 16'h3A70, 4'h0);
    step(1'b0, 1'b1, 16'h3A70, 4'h0);
    step(1'b0, 1'b1, 16'h3A70, 4'h0);
    chk("resume_tick", 32'(tick_actualizacion), 32'(1));

    go_to(6, 2, 16'h3A70, 4'h0);
    step(1'b1, 1'b1, 16'h3A70, 4'h0);
    chk("midreset_sel", 32'(digito_sel), 32'(0));
    for (int i = 0; i < DIV; i++) step(1'b0, 1'b1, 16'h3A70, 4'h0);
    chk("tick_after_reset", 32'(tick_actualizacion), 32'(1));

    for (int i = 0; i < ND * DIV; i++) step(1'b0, 1'b1, 16'h3A70, 4'b0100);

    go_to(4, 0, 16'h0001, 4'h0);
    step(1'b0, 1'b1, 16'h0008, 4'h0);
    chk("midslot_seg", 32'(segmentos), 32'h00);
    chk("midslot_an", 32'(anodos), 32'hE);
    step(1'b0, 1'b1, 16'h0008, 4'h0);

    d = 16'h1234;
    pt = 4'h0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) d = 16'($urandom);
      if ($urandom_range(0, 15) == 0) pt = 4'($urandom);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, d, pt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/barrido_display.md
Name: barrido_display

Overview:
- Drives the multiplexed 7-segment display that shows the decoded Gray value.
- Divides the system clock into refresh slots, emits a one-cycle refresh tick per slot, and advances the digit selector.
- Drives active-low anodes and segments, with a blanking guard at each digit change to suppress ghosting.
- The refresh tick is the update event consumed by the refresh counter; this block is the producer end of that interface.

Parameters:
- DIV, 100000: clock cycles per refresh slot; legal range ≥ 4.
- BLANK, 16: cycles at the start of each slot with all anodes off; legal range 1 ≤ BLANK < DIV.
- N_DIGITOS, 4: number of digits; legal range ≥ 2, need not be a power of 2.
- SELW, $clog2(N_DIGITOS): digito_sel width; derived, not overridden.

Ports:
- reloj, input, 1: system clock; all logic on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- habilitar, input, 1: scan enable.
- digitos, input, 4*N_DIGITOS: hex nibble per digit; digit i = bits [4i+3:4i].
- puntos, input, N_DIGITOS: decimal point per digit, active-high request.
- tick_actualizacion, output, 1: one-cycle pulse at each slot boundary.
- digito_sel, output, SELW: index of the digit in the current slot.
- anodos, output, N_DIGITOS: active-low digit enables.
- segmentos, output, 7: active-low, ordered [6:0] = g,f,e,d,c,b,a.
- punto, output, 1: active-low decimal point.

Behaviour:
- Reset (reset=1 at an edge):
  - Internal prescaler = 0; digito_sel = 0; tick_actualizacion = 0.
  - anodos = all 1; segmentos = 7'h7F; punto = 1.
  - Reset wins over every other condition, including mid-slot.
- Prescaler (habilitar=1):
  - Counts 0..DIV-1, then wraps to 0.
  - In the cycle where prescaler == DIV-1: tick_actualizacion = 1 (registered, visible the following cycle). digito_sel advances on that same edge: N_DIGITOS-1 wraps to 0, otherwise increments.
  - Net effect: the tick pulse and the new digito_sel value appear together in the first cycle of the new slot.
- habilitar=0:
  - Prescaler and digito_sel hold; tick_actualizacion = 0.
  - Next edge: anodos = all 1, segmentos = 7'h7F, punto = 1.
  - Re-enabling resumes counting from the held prescaler value.
- Output pipeline: all display outputs are registered with 1-cycle latency from the state and inputs.
  - Let p and s be the prescaler and digito_sel values in cycle t.
  - In cycle t+1, when habilitar=1 in cycle t:
    - anodos[i] = 0 iff i == s and p ≥ BLANK; otherwise 1.
    - segmentos = decode(digitos[4s+3:4s]) when p ≥ BLANK, else 7'h7F.
    - punto = ~puntos[s] when p ≥ BLANK, else 1.
- Blanking: in every slot, the first BLANK prescaler counts have all anodes off, so no two anodes are ever low simultaneously, including at wrap N_DIGITOS-1 → 0.
- Decode table (hex value → segmentos, active-low, gfedcba):
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
- Input changes:
  - digitos and puntos are sampled every cycle.
  - A change mid-slot appears on segmentos/punto one cycle later; the anode stays on and the slot is not restarted.
- At most one anode is low at any time; assertion required in the bench.

Test Plan:
- Sim parameters for all cases: DIV=8, BLANK=2, N_DIGITOS=4.
- Reset, then habilitar=1, digitos=16'h3A70 → tick_actualizacion every 8th cycle. digito_sel sequence 0,1,2,3,0. While each digit is active, segmentos = 40, 78, 08, 30 for digits 0..3 (digit0=0, digit1=7, digit2=A, digit3=3). anodos go 1110 → 1101 → 1011 → 0111, each preceded by 2 cycles of 1111.
- Wrap and ghosting: run 100 slots → never more than one anodos bit low; the first 2 cycles of every slot show anodos=1111 and segmentos=7F.
- habilitar dropped mid-slot at prescaler=5 for 10 cycles → outputs blank next cycle, no tick, digito_sel held. On re-enable, the tick arrives 3 cycles after counting resumes.
- Reset asserted at prescaler=6, digito_sel=2 → next cycle: anodos=1111, segmentos=7F, digito_sel=0, tick=0. The next tick occurs 8 cycles after reset is released.
- puntos=4'b0100, digito_sel=2 active → punto=0 only during digit 2's unblanked cycles.
- Mid-slot change: digitos nibble 0 changes 1→8 at prescaler=4 while digit 0 is active → segmentos changes 79→00 one cycle later; anodos stays 1110.
